// File: rtl/bus_ram_responder_if.sv
// rd/we/ack memory bus between an initiator and bus_ram_responder.
// err_o exists only when RAM_BOUNDS_CHECK_EN is defined.
interface bus_ram_responder_if;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        we_i;
  logic        rd_i;
  logic        ack_o;
`ifdef RAM_BOUNDS_CHECK_EN
  logic        err_o;

  modport master (
    output addr_i, data_i, we_i, rd_i,
    input  data_o, ack_o, err_o
  );
  modport slave (
    input  addr_i, data_i, we_i, rd_i,
    output data_o, ack_o, err_o
  );
`else
  modport master (
    output addr_i, data_i, we_i, rd_i,
    input  data_o, ack_o
  );
  modport slave (
    input  addr_i, data_i, we_i, rd_i,
    output data_o, ack_o
  );
`endif
endinterface

// File: rtl/bus_ram_responder.sv
// Single-port word RAM responder with programmable wait states.
// Define RAM_BOUNDS_CHECK_EN to flag out-of-range addresses on err_o.
module bus_ram_responder #(
  parameter int DEPTH       = 4096,
  parameter int WAIT_CYCLES = 2
) (
  input logic                clk,
  input logic                rst,
  bus_ram_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WAIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t        state, state_n;
  logic [3:0]    cnt, cnt_n;
  logic [AW-1:0] idx_q, idx;
  logic [31:0]   wd_q, wd;
  logic          we_q, we;
  logic          oob_q, oob;
  logic          hi_nz;
  logic          req;
  logic          go_ack;
  logic [31:0]   data_q;
  logic [31:0]   ram [DEPTH];
  logic          unused;

  assign unused = ^{bus.addr_i[1:0], bus.addr_i[31:AW+2]};
  assign req    = bus.rd_i | bus.we_i;

`ifdef RAM_BOUNDS_CHECK_EN
  assign hi_nz      = |bus.addr_i[31:AW+2];
  assign bus.err_o  = (state == S_ACK) & oob_q;
`else
  assign hi_nz      = 1'b0;
`endif

  // In IDLE the live bus is used so WAIT_CYCLES=0 can commit same edge.
  always_comb begin
    idx = idx_q;
    wd  = wd_q;
    we  = we_q;
    oob = oob_q;
    if (state == S_IDLE) begin
      idx = bus.addr_i[AW+1:2];
      wd  = bus.data_i;
      we  = bus.we_i;
      oob = hi_nz;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    go_ack  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (req) begin
          cnt_n = WAIT;
          if (WAIT == 4'd0) begin
            state_n = S_ACK;
            go_ack  = 1'b1;
          end else begin
            state_n = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt - 4'd1;
          if (cnt == 4'd1) begin
            state_n = S_ACK;
            go_ack  = 1'b1;
          end
        end
      end
      S_ACK:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= S_IDLE;
      cnt    <= 4'd0;
      idx_q  <= '0;
      wd_q   <= 32'h0;
      we_q   <= 1'b0;
      oob_q  <= 1'b0;
      data_q <= 32'h0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (state == S_IDLE) begin
        idx_q <= idx;
        wd_q  <= wd;
        we_q  <= we;
        oob_q <= oob;
      end
      if (go_ack && !we) begin
        data_q <= oob ? 32'hDEAD_BEEF : ram[idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst && go_ack && we && !oob) begin
      ram[idx] <= wd;
    end
  end

  assign bus.data_o = data_q;
  assign bus.ack_o  = (state == S_ACK);
endmodule

// File: tb/tb_bus_ram_responder.sv
// Directed bench for bus_ram_responder at WAIT_CYCLES 0, 2 and 3.
// Alias vs bounds-check expectations follow RAM_BOUNDS_CHECK_EN.
module tb_bus_ram_responder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bus_ram_responder_if b0 ();
  bus_ram_responder_if b2 ();
  bus_ram_responder_if b3 ();

  bus_ram_responder #(.DEPTH(4096), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .rst(rst), .bus(b0.slave));
  bus_ram_responder #(.DEPTH(4096), .WAIT_CYCLES(2)) u2 (
    .clk(clk), .rst(rst), .bus(b2.slave));
  bus_ram_responder #(.DEPTH(4096), .WAIT_CYCLES(3)) u3 (
    .clk(clk), .rst(rst), .bus(b3.slave));

  int          sel;
  logic        rd_v, we_v;
  logic [31:0] addr_v, wdata_v;
  logic        ack_m;
  logic [31:0] data_m;
  logic        err_m;

  assign b0.rd_i   = rd_v & (sel == 0);
  assign b0.we_i   = we_v & (sel == 0);
  assign b0.addr_i = addr_v;
  assign b0.data_i = wdata_v;
  assign b2.rd_i   = rd_v & (sel == 2);
  assign b2.we_i   = we_v & (sel == 2);
  assign b2.addr_i = addr_v;
  assign b2.data_i = wdata_v;
  assign b3.rd_i   = rd_v & (sel == 3);
  assign b3.we_i   = we_v & (sel == 3);
  assign b3.addr_i = addr_v;
  assign b3.data_i = wdata_v;

  always_comb begin
    ack_m  = b2.ack_o;
    data_m = b2.data_o;
    err_m  = 1'b0;
`ifdef RAM_BOUNDS_CHECK_EN
    err_m  = b2.err_o;
`endif
    case (sel)
      0: begin
        ack_m  = b0.ack_o;
        data_m = b0.data_o;
      end
      3: begin
        ack_m  = b3.ack_o;
        data_m = b3.data_o;
      end
      default: ;
    endcase
  end

  int n_chk = 0;
  int n_fail = 0;
  logic ack_after;
  logic err_seen;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pat(input logic [31:0] base,
                                      input int i);
    return base ^ (32'(i) * 32'h0101_0101);
  endfunction

  // Called at a negedge with the request already driven.
  task automatic wait_ack(output logic [31:0] q, output int lat);
    logic got;
    got = 1'b0;
    lat = -1;
    q = 32'h0;
    err_seen = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (ack_m) begin
        got = 1'b1;
        lat = i;
        q = data_m;
        err_seen = err_m;
        break;
      end
    end
    rd_v = 1'b0;
    we_v = 1'b0;
    chk("ack_seen", 32'(got), 32'd1);
    @(negedge clk);
    ack_after = ack_m;
  endtask

  task automatic bus_op(input logic r, input logic w,
                        input logic [31:0] a,
                        input logic [31:0] d,
                        output logic [31:0] q,
                        output int lat);
    rd_v = r;
    we_v = w;
    addr_v = a;
    wdata_v = d;
    wait_ack(q, lat);
  endtask

  task automatic count_acks(input int cyc, output int n);
    n = 0;
    for (int i = 0; i < cyc; i++) begin
      @(negedge clk);
      if (ack_m) n++;
    end
  endtask

  task automatic burst(input logic [31:0] a0, input int n,
                       input int gap, input logic [31:0] base);
    int last;
    int k;
    last = 0;
    k = 0;
    rd_v = 1'b1;
    addr_v = a0;
    for (int t = 1; t <= n * (gap + 2) + 20 && k < n; t++) begin
      @(negedge clk);
      if (ack_m) begin
        chk("burst_data", data_m, pat(base, k));
        if (k > 0) chk("burst_gap", 32'(t - last), 32'(gap));
        else chk("burst_first", 32'(t), 32'(gap - 1));
        last = t;
        k++;
        addr_v = addr_v + 32'd4;
        if (k == n) rd_v = 1'b0;
      end
    end
    rd_v = 1'b0;
    chk("burst_count", 32'(k), 32'(n));
    @(negedge clk);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] q;
    int lat;
    int n;
    rst = 1'b0;
    rd_v = 1'b0;
    we_v = 1'b0;
    addr_v = 32'h0;
    wdata_v = 32'h0;
    sel = 2;
    repeat (3) @(negedge clk);
    chk("rst_ack0", 32'(b0.ack_o), 32'd0);
    chk("rst_ack2", 32'(b2.ack_o), 32'd0);
    chk("rst_ack3", 32'(b3.ack_o), 32'd0);
    chk("rst_data2", b2.data_o, 32'h0);
    chk("rst_data3", b3.data_o, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    bus_op(1'b0, 1'b1, 32'h40, 32'h1234_5678, q, lat);
    chk("wr_lat", 32'(lat), 32'd3);
    chk("wr_ack_pulse", 32'(ack_after), 32'd0);
    bus_op(1'b1, 1'b0, 32'h40, 32'h0, q, lat);
    chk("rd_lat", 32'(lat), 32'd3);
    chk("rd_data", q, 32'h1234_5678);
    chk("rd_ack_pulse", 32'(ack_after), 32'd0);
    bus_op(1'b0, 1'b1, 32'h44, 32'h0F0F_0F0F, q, lat);
    chk("wr_holds_data", q, 32'h1234_5678);

    for (int i = 0; i < 16; i++)
      bus_op(1'b0, 1'b1, 32'h100 + 32'(4 * i),
             pat(32'hA5C3_0000, i), q, lat);
    burst(32'h100, 16, 4, 32'hA5C3_0000);

    sel = 0;
    bus_op(1'b0, 1'b1, 32'h10, pat(32'h3C00_0010, 0), q, lat);
    chk("w0_wr_lat", 32'(lat), 32'd1);
    for (int i = 1; i < 4; i++)
      bus_op(1'b0, 1'b1, 32'h10 + 32'(4 * i),
             pat(32'h3C00_0010, i), q, lat);
    bus_op(1'b1, 1'b0, 32'h10, 32'h0, q, lat);
    chk("w0_rd_lat", 32'(lat), 32'd1);
    chk("w0_rd_data", q, 32'h3C00_0010);
    burst(32'h10, 4, 2, 32'h3C00_0010);

    sel = 3;
    bus_op(1'b0, 1'b1, 32'h80, 32'h5555_AAAA, q, lat);
    chk("w3_wr_lat", 32'(lat), 32'd4);
    bus_op(1'b0, 1'b1, 32'h84, 32'h8484_8484, q, lat);
    rd_v = 1'b1;
    addr_v = 32'h80;
    @(negedge clk);
    rd_v = 1'b0;
    count_acks(8, n);
    chk("abort_rd_noack", 32'(n), 32'd0);
    bus_op(1'b1, 1'b0, 32'h84, 32'h0, q, lat);
    chk("after_abort_lat", 32'(lat), 32'd4);
    chk("after_abort_data", q, 32'h8484_8484);
    we_v = 1'b1;
    addr_v = 32'h80;
    wdata_v = 32'hFFFF_FFFF;
    @(negedge clk);
    we_v = 1'b0;
    count_acks(8, n);
    chk("abort_wr_noack", 32'(n), 32'd0);
    bus_op(1'b1, 1'b0, 32'h80, 32'h0, q, lat);
    chk("abort_wr_ram", q, 32'h5555_AAAA);
    rd_v = 1'b1;
    addr_v = 32'h84;
    @(negedge clk);
    addr_v = 32'h80;
    wait_ack(q, lat);
    chk("addr_latched_lat", 32'(lat), 32'd3);
    chk("addr_latched", q, 32'h8484_8484);

    sel = 2;
    bus_op(1'b0, 1'b1, 32'h20, 32'h0BAD_F00D, q, lat);
    bus_op(1'b1, 1'b0, 32'h20, 32'h0, q, lat);
    we_v = 1'b1;
    addr_v = 32'h20;
    wdata_v = 32'h1111_2222;
    @(negedge clk);
    rst = 1'b0;
    we_v = 1'b0;
    @(negedge clk);
    chk("midrst_ack", 32'(b2.ack_o), 32'd0);
    chk("midrst_data", b2.data_o, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    bus_op(1'b1, 1'b0, 32'h20, 32'h0, q, lat);
    chk("midrst_ram", q, 32'h0BAD_F00D);

    bus_op(1'b1, 1'b1, 32'h24, 32'hCAFE_0024, q, lat);
    chk("both_lat", 32'(lat), 32'd3);
    chk("both_data_hold", q, 32'h0BAD_F00D);
    count_acks(6, n);
    chk("both_single_ack", 32'(n), 32'd0);
    bus_op(1'b1, 1'b0, 32'h24, 32'h0, q, lat);
    chk("both_wrote", q, 32'hCAFE_0024);

`ifdef RAM_BOUNDS_CHECK_EN
    bus_op(1'b0, 1'b1, 32'h0, 32'h0000_A0A0, q, lat);
    chk("w_in_err", 32'(err_seen), 32'd0);
    bus_op(1'b1, 1'b0, 32'h4000, 32'h0, q, lat);
    chk("oob_rd_lat", 32'(lat), 32'd3);
    chk("oob_rd_err", 32'(err_seen), 32'd1);
    chk("oob_rd_data", q, 32'hDEAD_BEEF);
    bus_op(1'b0, 1'b1, 32'h4000, 32'h9999_9999, q, lat);
    chk("oob_wr_err", 32'(err_seen), 32'd1);
    bus_op(1'b1, 1'b0, 32'h0, 32'h0, q, lat);
    chk("oob_wr_discard", q, 32'h0000_A0A0);
    chk("in_rd_err", 32'(err_seen), 32'd0);
`else
    bus_op(1'b0, 1'b1, 32'h0, 32'h0000_A0A0, q, lat);
    bus_op(1'b0, 1'b1, 32'h4000, 32'h7777_0000, q, lat);
    bus_op(1'b1, 1'b0, 32'h0, 32'h0, q, lat);
    chk("alias_word0", q, 32'h7777_0000);
    bus_op(1'b1, 1'b0, 32'h8000_4040, 32'h0, q, lat);
    chk("alias_hi", q, 32'h1234_5678);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
